// File: rtl/lsu_wb_pkg.sv
// lsu_wb_pkg: shared definitions for the load/store Wishbone initiator.
//   - lsu_state_t : bus-sequencing states (IDLE, BUS, RECOVER)
//   - F3_*        : RISC-V load/store funct3 encodings
//   - LSU_TIMEOUT_CYCLES_DEFAULT : default ack wait limit, only meaningful
//     when the design is built with LSU_WB_TIMEOUT_EN defined
package lsu_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUS     = 2'd1,
    ST_RECOVER = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LSU_TIMEOUT_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/lsu_align_check.sv
// lsu_align_check: combinational alignment check for one load/store request.
// Ports:
//   we         in  : 1 = store, 0 = load
//   funct3     in  : RISC-V funct3 of the access
//   addr_lsb   in  : two least-significant byte-address bits
//   misaligned out : 1 when the access does not sit on its natural boundary
module lsu_align_check
  import lsu_wb_pkg::*;
(
  input  logic       we,
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lsb,
  output logic       misaligned
);

  // Loads size themselves from funct3[1:0] (the sign bit is irrelevant here),
  // so 10 and 11 both act as word. Stores only know sb/sh/sw, and every other
  // encoding is treated as a word store.
  always_comb begin
    misaligned = 1'b0;
    if (we) begin
      case (funct3)
        F3_B:    misaligned = 1'b0;
        F3_H:    misaligned = addr_lsb[0];
        default: misaligned = |addr_lsb;
      endcase
    end else begin
      case (funct3[1:0])
        2'b00:   misaligned = 1'b0;
        2'b01:   misaligned = addr_lsb[0];
        default: misaligned = |addr_lsb;
      endcase
    end
  end

endmodule

// File: rtl/lsu_wb_master.sv
// lsu_wb_master: Wishbone initiator for the core's data-memory loads/stores.
// Accepts one request at a time, rejects misaligned ones without a bus cycle,
// otherwise runs a single Wishbone cycle and returns a one-cycle response.
// Optional feature macro: LSU_WB_TIMEOUT_EN -- when defined, a BUS cycle that
// sees no ack for TIMEOUT_CYCLES cycles is abandoned with an error response.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid_i/req_ready_o  : core request handshake
//   req_we_i, req_addr_i, req_wdata_i, req_funct3_i : request fields
//   resp_valid_o, resp_rdata_o, resp_err_o : completion pulse, load data, error
//   wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, funct3_o : bus outputs
//   wb_dat_i, wb_ack_i       : responder read data (already extended) and ack
module lsu_wb_master
  import lsu_wb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 7,
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [2:0]            req_funct3_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic [2:0]            funct3_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i
);

  lsu_state_t            state_q, state_d;
  logic                  cyc_d, we_d;
  logic [ADDR_WIDTH-1:0] adr_d;
  logic [DATA_WIDTH-1:0] dat_d;
  logic [2:0]            f3_d;
  logic                  resp_valid_d, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata_d;
  logic                  misaligned;
  logic                  accept;
  logic                  tmo_hit;

  lsu_align_check u_align (
    .we        (req_we_i),
    .funct3    (req_funct3_i),
    .addr_lsb  (req_addr_i[1:0]),
    .misaligned(misaligned)
  );

  // Ready is held low while rst is asserted even though the state is IDLE.
  assign req_ready_o = (state_q == ST_IDLE) && !rst;
  assign accept      = req_valid_i && req_ready_o;
  assign wb_stb_o    = wb_cyc_o;

`ifdef LSU_WB_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  // The counter holds the number of ack-less BUS cycles already completed,
  // so the limit fires on the TIMEOUT_CYCLES-th ack-less cycle.
  assign tmo_hit = (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) tmo_cnt_q <= 8'd0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  // Bus outputs are zero everywhere except BUS, so every exit from BUS
  // clears them and the IDLE/RECOVER states just hold the cleared values.
  always_comb begin
    state_d      = state_q;
    cyc_d        = wb_cyc_o;
    we_d         = wb_we_o;
    adr_d        = wb_adr_o;
    dat_d        = wb_dat_o;
    f3_d         = funct3_o;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_o;
`ifdef LSU_WB_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (misaligned) begin
            state_d      = ST_RECOVER;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d = ST_BUS;
            cyc_d   = 1'b1;
            we_d    = req_we_i;
            adr_d   = req_addr_i;
            dat_d   = req_wdata_i;
            f3_d    = req_funct3_i;
`ifdef LSU_WB_TIMEOUT_EN
            tmo_cnt_d = 8'd0;
`endif
          end
        end
      end
      ST_BUS: begin
        if (wb_ack_i || tmo_hit) begin
          state_d      = ST_RECOVER;
          resp_valid_d = 1'b1;
          resp_err_d   = !wb_ack_i;
          resp_rdata_d = (wb_ack_i && !wb_we_o) ? wb_dat_i : '0;
          cyc_d        = 1'b0;
          we_d         = 1'b0;
          adr_d        = '0;
          dat_d        = '0;
          f3_d         = '0;
        end
`ifdef LSU_WB_TIMEOUT_EN
        else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
`endif
      end
      // The responder's registered ack is still high here; it is ignored.
      ST_RECOVER: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
        adr_d   = '0;
        dat_d   = '0;
        f3_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wb_cyc_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_adr_o     <= '0;
      wb_dat_o     <= '0;
      funct3_o     <= '0;
      resp_valid_o <= 1'b0;
      resp_err_o   <= 1'b0;
      resp_rdata_o <= '0;
    end else begin
      state_q      <= state_d;
      wb_cyc_o     <= cyc_d;
      wb_we_o      <= we_d;
      wb_adr_o     <= adr_d;
      wb_dat_o     <= dat_d;
      funct3_o     <= f3_d;
      resp_valid_o <= resp_valid_d;
      resp_err_o   <= resp_err_d;
      resp_rdata_o <= resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_wb_master.sv
// tb_lsu_wb_master: self-checking bench for lsu_wb_master with a byte-addressed
// memory responder (registered ack, combinational funct3-extended read data)
// and a byte-array reference model of loads, stores and alignment.
// Build with LSU_WB_TIMEOUT_EN defined to also exercise the ack timeout.
module tb_lsu_wb_master;
  import lsu_wb_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [6:0]  req_addr_i;
  logic [31:0] req_wdata_i;
  logic [2:0]  req_funct3_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [6:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [2:0]  funct3_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  int passCount = 0;
  int checkCount = 0;

  logic [7:0] mem [0:127];
  logic [7:0] refMem [0:127];
  logic       memInit;
  logic       ackEnable;

  lsu_wb_master #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_funct3_i(req_funct3_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .resp_err_o(resp_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .funct3_o(funct3_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 73 + 19) & 255);
  endfunction

  // Data-memory responder: ack follows stb by one edge, so it stays high for
  // one extra cycle after the master drops cyc.
  always @(posedge clk) begin
    if (rst) wb_ack_i <= 1'b0;
    else     wb_ack_i <= wb_cyc_o & wb_stb_o & ackEnable;
    if (memInit) begin
      for (int i = 0; i < 128; i++) mem[i] <= pat(i);
    end else if (wb_cyc_o && wb_stb_o && wb_we_o) begin
      mem[wb_adr_o] <= wb_dat_o[7:0];
      if (funct3_o != F3_B) mem[wb_adr_o + 7'd1] <= wb_dat_o[15:8];
      if (funct3_o != F3_B && funct3_o != F3_H) begin
        mem[wb_adr_o + 7'd2] <= wb_dat_o[23:16];
        mem[wb_adr_o + 7'd3] <= wb_dat_o[31:24];
      end
    end
  end

  always_comb begin
    wb_dat_i = {mem[wb_adr_o + 7'd3], mem[wb_adr_o + 7'd2],
                mem[wb_adr_o + 7'd1], mem[wb_adr_o]};
    case (funct3_o)
      F3_B:  wb_dat_i = {{24{mem[wb_adr_o][7]}}, mem[wb_adr_o]};
      F3_BU: wb_dat_i = {24'd0, mem[wb_adr_o]};
      F3_H:  wb_dat_i = {{16{mem[wb_adr_o + 7'd1][7]}}, mem[wb_adr_o + 7'd1], mem[wb_adr_o]};
      F3_HU: wb_dat_i = {16'd0, mem[wb_adr_o + 7'd1], mem[wb_adr_o]};
      default: ;
    endcase
  end

  // Reference model: access size in bytes, alignment and byte-array contents.
  function automatic int accessSize(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic modelMisaligned(input logic we, input logic [6:0] addr,
                                           input logic [2:0] f3);
    return (int'(addr) % accessSize(we, f3)) != 0;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [6:0] addr, input logic [2:0] f3);
    int size = accessSize(1'b0, f3);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < size; i++) v = v | (32'(refMem[(int'(addr) + i) % 128]) << (8 * i));
    if (size < 4 && !f3[2] && v[8 * size - 1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
    return v;
  endfunction

  task automatic modelStore(input logic [6:0] addr, input logic [2:0] f3, input logic [31:0] wdata);
    int size = accessSize(1'b1, f3);
    for (int i = 0; i < size; i++) refMem[(int'(addr) + i) % 128] = 8'(wdata >> (8 * i));
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
  endtask

  // One complete request: wait for ready, present it for one cycle, check the
  // bus cycle (or its absence), the response latency, error flag and data.
  task automatic applyStimulus(input logic we, input logic [6:0] addr, input logic [2:0] f3,
                               input logic [31:0] wdata, input string tag,
                               output logic [31:0] rdata);
    int waitCnt = 0;
    int lat;
    logic mis;
    logic [31:0] expData;
    while (!req_ready_o && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput({tag, " ready"}, 32'(req_ready_o), 32'd1);
    mis     = modelMisaligned(we, addr, f3);
    expData = (we || mis) ? 32'd0 : modelLoad(addr, f3);
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    req_funct3_i = f3;
    @(negedge clk);
    req_valid_i = 1'b0;
    checkOutput({tag, " cyc"}, 32'(wb_cyc_o), 32'(!mis));
    checkOutput({tag, " stb"}, 32'(wb_stb_o), 32'(!mis));
    if (!mis) begin
      checkOutput({tag, " adr"}, 32'(wb_adr_o), 32'(addr));
      checkOutput({tag, " we"}, 32'(wb_we_o), 32'(we));
      checkOutput({tag, " funct3"}, 32'(funct3_o), 32'(f3));
      if (we) checkOutput({tag, " wdat"}, wb_dat_o, wdata);
    end
    lat = 1;
    while (!resp_valid_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, " latency"}, 32'(lat), mis ? 32'd1 : 32'd3);
    checkOutput({tag, " err"}, 32'(resp_err_o), 32'(mis));
    checkOutput({tag, " rdata"}, resp_rdata_o, expData);
    rdata = resp_rdata_o;
    if (we && !mis) modelStore(addr, f3, wdata);
    @(negedge clk);
    checkOutput({tag, " pulse"}, 32'(resp_valid_o), 32'd0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed no finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] expData;
    logic [6:0]  addr;
    logic [2:0]  f3;
    logic        we;
    int          cnt;
    int          respSeen;
    logic        cycAt16;

    rst = 1'b1; memInit = 1'b1; ackEnable = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0;
    req_wdata_i = '0; req_funct3_i = '0;
    for (int i = 0; i < 128; i++) refMem[i] = pat(i);
    repeat (3) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst ready", 32'(req_ready_o), 32'd0);
    checkOutput("rst resp_valid", 32'(resp_valid_o), 32'd0);
    checkOutput("rst resp_err", 32'(resp_err_o), 32'd0);
    checkOutput("rst resp_rdata", resp_rdata_o, 32'd0);
    checkOutput("rst cyc", 32'(wb_cyc_o), 32'd0);
    checkOutput("rst stb", 32'(wb_stb_o), 32'd0);
    checkOutput("rst we", 32'(wb_we_o), 32'd0);
    checkOutput("rst adr", 32'(wb_adr_o), 32'd0);
    checkOutput("rst dat", wb_dat_o, 32'd0);
    checkOutput("rst funct3", 32'(funct3_o), 32'd0);
    rst = 1'b0; memInit = 1'b0;
    @(negedge clk);
    checkOutput("post-rst ready", 32'(req_ready_o), 32'd1);

    $display("[TB] directed loads and stores");
    applyStimulus(1'b1, 7'h10, F3_W, 32'hDEADBEEF, "sw 0x10", rd);
    applyStimulus(1'b0, 7'h10, F3_W, 32'd0, "lw 0x10", rd);
    checkOutput("lw 0x10 value", rd, 32'hDEADBEEF);
    applyStimulus(1'b1, 7'h21, F3_B, 32'h12345680, "sb 0x21", rd);
    applyStimulus(1'b0, 7'h21, F3_B, 32'd0, "lb 0x21", rd);
    checkOutput("lb 0x21 value", rd, 32'hFFFFFF80);
    applyStimulus(1'b0, 7'h21, F3_BU, 32'd0, "lbu 0x21", rd);
    checkOutput("lbu 0x21 value", rd, 32'h00000080);
    applyStimulus(1'b0, 7'h03, F3_H, 32'd0, "lh 0x03", rd);
    applyStimulus(1'b1, 7'h06, F3_W, 32'h0, "sw 0x06", rd);
    applyStimulus(1'b1, 7'h05, F3_BU, 32'h0, "s-f3=100 0x05", rd);
    applyStimulus(1'b0, 7'h7E, F3_HU, 32'd0, "lhu 0x7e", rd);

    $display("[TB] random transactions");
    for (int n = 0; n < 40; n++) begin
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) addr = 7'(int'(addr) - (int'(addr) % accessSize(we, f3)));
      applyStimulus(we, addr, f3, $urandom, $sformatf("rand%0d", n), rd);
    end

    $display("[TB] back-to-back requests");
    checkOutput("b2b start ready", 32'(req_ready_o), 32'd1);
    expData = modelLoad(7'h10, F3_W);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 7'h10; req_funct3_i = F3_W;
    for (int k = 0; k < 12; k++) begin
      checkOutput($sformatf("b2b ready c%0d", k), 32'(req_ready_o), 32'((k % 4) == 0));
      checkOutput($sformatf("b2b resp c%0d", k), 32'(resp_valid_o), 32'((k % 4) == 3));
      if ((k % 4) == 3) checkOutput($sformatf("b2b rdata c%0d", k), resp_rdata_o, expData);
      if (k == 11) req_valid_i = 1'b0;
      @(negedge clk);
    end

    $display("[TB] stalled ack");
    expData = modelLoad(7'h20, F3_W);
    ackEnable = 1'b0;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 7'h20; req_funct3_i = F3_W;
    @(negedge clk);
    req_valid_i = 1'b0;
    respSeen = 0;
    for (int c = 1; c < 10; c++) begin
      if (resp_valid_o) respSeen++;
      @(negedge clk);
    end
    checkOutput("stall cyc held", 32'(wb_cyc_o), 32'd1);
    checkOutput("stall adr held", 32'(wb_adr_o), 32'h20);
    checkOutput("stall no resp", 32'(respSeen), 32'd0);
    ackEnable = 1'b1;
    cnt = 0;
    while (!resp_valid_o && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("stall resp cycles", 32'(cnt), 32'd2);
    checkOutput("stall err", 32'(resp_err_o), 32'd0);
    checkOutput("stall rdata", resp_rdata_o, expData);
    repeat (2) @(negedge clk);

    $display("[TB] reset during bus cycle");
    checkOutput("rstbus start ready", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 7'h24; req_funct3_i = F3_W;
    @(negedge clk);
    req_valid_i = 1'b0;
    checkOutput("rstbus cyc before", 32'(wb_cyc_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstbus cyc", 32'(wb_cyc_o), 32'd0);
    checkOutput("rstbus stb", 32'(wb_stb_o), 32'd0);
    checkOutput("rstbus resp", 32'(resp_valid_o), 32'd0);
    checkOutput("rstbus ready in rst", 32'(req_ready_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstbus idle ready", 32'(req_ready_o), 32'd1);
    checkOutput("rstbus stale ack no resp", 32'(resp_valid_o), 32'd0);
    @(negedge clk);
    checkOutput("rstbus still no resp", 32'(resp_valid_o), 32'd0);

`ifdef LSU_WB_TIMEOUT_EN
    $display("[TB] ack timeout");
    ackEnable = 1'b0;
    cycAt16 = 1'b0;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 7'h30; req_funct3_i = F3_W;
    @(negedge clk);
    req_valid_i = 1'b0;
    cnt = 1;
    while (!resp_valid_o && cnt < 40) begin
      if (cnt == 16) cycAt16 = wb_cyc_o;
      @(negedge clk);
      cnt++;
    end
    checkOutput("tmo cyc at 16", 32'(cycAt16), 32'd1);
    checkOutput("tmo resp cycle", 32'(cnt), 32'd17);
    checkOutput("tmo err", 32'(resp_err_o), 32'd1);
    checkOutput("tmo rdata", resp_rdata_o, 32'd0);
    checkOutput("tmo cyc dropped", 32'(wb_cyc_o), 32'd0);
    ackEnable = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 7'h10, F3_W, 32'd0, "post-tmo lw", rd);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
